// File: rtl/branch_ctrl.sv
// Control-flow decode ahead of the PC: jump LUT, flag register and
// a small return-address stack driving jump_en/branch_en/destination.
module branch_ctrl #(
  parameter int LUT_DEPTH   = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       init,
  input  logic [8:0] instr,
  input  logic [9:0] PC,
  input  logic       halt,
  input  logic       flag_we,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       lut_we,
  input  logic [4:0] lut_addr,
  input  logic [9:0] lut_data,
  output logic       jump_en,
  output logic       branch_en,
  output logic [9:0] destination,
  output logic [2:0] depth,
  output logic       stack_err
);

  localparam int LAW = $clog2(LUT_DEPTH);
  localparam int SPW = $clog2(STACK_DEPTH);

  logic [9:0] lut_q [LUT_DEPTH];
  logic [9:0] lut_d [LUT_DEPTH];
  logic [9:0] stk_q [STACK_DEPTH];
  logic [9:0] stk_d [STACK_DEPTH];
  logic [2:0] depth_q, depth_d;
  logic       err_q, err_d;
  logic       z_q, z_d;
  logic       n_q, n_d;

  logic [2:0]     op;
  logic           is_jmp, is_br, is_call, is_ret;
  logic           active, full, empty, cond;
  logic           push, pop, bad;
  logic [SPW-1:0] wr_idx, top_idx;
  logic [9:0]     tgt;

  assign op      = instr[8:6];
  assign is_jmp  = (op == 3'b110);
  assign is_br   = (op == 3'b111);
  assign is_call = (op == 3'b101) && !instr[5];
  assign is_ret  = (op == 3'b101) && instr[5];
  assign active  = !init && !halt;
  assign full    = (depth_q == 3'(STACK_DEPTH));
  assign empty   = (depth_q == 3'd0);
  // depth==STACK_DEPTH wraps wr_idx to 0, but push is blocked then
  assign wr_idx  = depth_q[SPW-1:0];
  assign top_idx = wr_idx - SPW'(1);
  assign tgt     = lut_q[instr[LAW-1:0]];

  always_comb begin
    cond = 1'b0;
    unique case (instr[5:4])
      2'b00: cond = z_q;
      2'b01: cond = !z_q;
      2'b10: cond = n_q;
      2'b11: cond = !n_q;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    jump_en     = 1'b0;
    branch_en   = 1'b0;
    destination = 10'd0;
    push        = 1'b0;
    pop         = 1'b0;
    bad         = 1'b0;
    if (active) begin
      unique case (1'b1)
        is_jmp: begin
          jump_en     = 1'b1;
          destination = tgt;
        end
        is_br: branch_en = cond;
        is_call: begin
          if (!full) begin
            push        = 1'b1;
            jump_en     = 1'b1;
            destination = tgt;
          end else begin
            bad = 1'b1;
          end
        end
        is_ret: begin
          if (!empty) begin
            pop         = 1'b1;
            jump_en     = 1'b1;
            destination = stk_q[top_idx];
          end else begin
            bad = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lut_d   = lut_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    err_d   = err_q | bad;
    z_d     = flag_we ? alu_zero : z_q;
    n_d     = flag_we ? alu_neg : n_q;
    if (lut_we) lut_d[lut_addr[LAW-1:0]] = lut_data;
    if (push) begin
      stk_d[wr_idx] = PC + 10'd1;
      depth_d       = depth_q + 3'd1;
    end else if (pop) begin
      depth_d = depth_q - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (init) begin
      lut_q   <= '{default: '0};
      stk_q   <= '{default: '0};
      depth_q <= 3'd0;
      err_q   <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      lut_q   <= lut_d;
      stk_q   <= stk_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign depth     = depth_q;
  assign stack_err = err_q;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

- Control-flow decode stage that sits directly upstream of the program counter.
- Each cycle it examines the current instruction, the registered ALU condition flags and its own call stack.
- It produces the `jump_en`, `branch_en` and `destination` signals that the PC registers on the next `CLK` edge.
- It owns the 32-entry jump-target lookup table, the condition-flag register and a 4-deep return-address stack.

## Interface
Parameters:
- `LUT_DEPTH`, default 32: number of jump-target entries, indexed by `instr[4:0]`.
- `STACK_DEPTH`, default 4: return-address stack entries.

Ports:
- `CLK`: input, 1 bit. The only clock.
- `init`: input, 1 bit. Reset, synchronous and active-high.
- `instr`: input, 9 bits. Current instruction, already fetched at `PC`.
- `PC`: input, 10 bits. Current program counter, used for the return address.
- `halt`: input, 1 bit. From the PC; suppresses all control flow.
- `flag_we`: input, 1 bit. Latch the ALU flags this cycle.
- `alu_zero`: input, 1 bit. ALU result == 0.
- `alu_neg`: input, 1 bit. ALU result MSB.
- `lut_we`: input, 1 bit. Write the jump-target LUT.
- `lut_addr`: input, 5 bits. LUT write index.
- `lut_data`: input, 10 bits. LUT write data.
- `jump_en`: output, 1 bit. To the PC: load `destination`.
- `branch_en`: output, 1 bit. To the PC: skip the next instruction (PC+2).
- `destination`: output, 10 bits. To the PC: absolute jump target.
- `depth`: output, 3 bits. Current stack occupancy, 0..4.
- `stack_err`: output, 1 bit. Sticky overflow/underflow error.

## Operation
Decoding uses `op = instr[8:6]`. All other opcodes are non-control: all three control outputs are 0.

- **op 110, JMP:** `jump_en=1`, `destination=lut[instr[4:0]]`.
- **op 111, BR (skip-if):** condition is selected by `instr[5:4]`.
  - 00: Z. 01: !Z. 10: N. 11: !N.
  - Condition true gives `branch_en=1`, so the PC skips the following instruction (normally a JMP).
  - Condition false leaves `branch_en=0`.
- **op 101 with `instr[5]=0`, CALL:**
  - If `depth<4`: push `PC+1` (10-bit wrap, 1023+1=0), `depth++`, `jump_en=1`, `destination=lut[instr[4:0]]`.
  - If `depth==4`: no push, `jump_en=0`, `stack_err` set.
- **op 101 with `instr[5]=1`, RET:**
  - If `depth>0`: `jump_en=1`, `destination=top of stack`, pop on the clock edge, `depth--`.
  - If `depth==0`: `jump_en=0`, `destination=0`, `stack_err` set.
- **Flag register {Z,N}:** loaded from `{alu_zero, alu_neg}` on any edge where `flag_we=1`. BR always reads the registered value.
- **LUT:** written on edges where `lut_we=1`. The read is combinational from the registered array.
- **Output default:** `destination=0` whenever `jump_en=0`.
- **Output cone:** `jump_en`, `branch_en` and `destination` are combinational from `instr` and registered state. `depth` and `stack_err` are registered.
- **`halt=1`:**
  - All control outputs are forced to 0.
  - No push or pop occurs, and `stack_err` is not modified.
  - Flag and LUT writes still occur.

## Timing
- **`init=1` at an edge:**
  - Z=N=0, `depth=0`, `stack_err=0`, all LUT entries and stack entries set to 0.
  - While `init=1`, `jump_en`, `branch_en` and `destination` are forced to 0.
  - `init` mid-CALL or mid-RET wins: no push or pop commits.
- **Latency:** control outputs are valid in the same cycle as `instr`. The PC acts on them at the next edge, so the redirect is visible one cycle after the instruction is presented.
- **Flag write and BR in the same cycle:** BR uses the OLD flags. New flags are visible from the next cycle.
- **LUT write and JMP/CALL to the same index in the same cycle:** `destination` is the OLD entry. The new entry is visible from the next cycle.
- **Stack behaviour:**
  - LIFO.
  - The stack pointer saturates at 0 and 4 and never wraps.
  - An erroneous op leaves both the stack contents and `depth` unchanged.
- **`stack_err`:** sticky until `init`. It is set on the edge following the offending instruction.
- **Ordering:** at most one stack operation per cycle. Push and pop commit on the same edge at which the PC loads `destination`.

## Test plan
- **Reset:** assert `init` for 2 cycles with `instr=9'b110_0_00011` → `jump_en=0`, `destination=0`, `depth=0`, `stack_err=0`. After release, `lut[3]=0` gives `jump_en=1`, `destination=0`.
- **LUT/JMP:** write `lut[5]=10'd200`, then on the next cycle `instr=110_0_00101` → `jump_en=1`, `destination=200`. Writing `lut[5]=300` in the same cycle as the JMP still yields 200, and the following cycle yields 300.
- **Branch:**
  - `flag_we=1` with `alu_zero=1`, then BEQ (`111_00_xxxx`) → `branch_en=1`.
  - BNE (`111_01_xxxx`) → `branch_en=0`.
  - Raising `flag_we` with `alu_zero=0` in the same cycle as a BEQ still gives `branch_en=1`.
- **CALL/RET:**
  - Set `lut[1]=40`. At `PC=10`, CALL idx 1 → `destination=40`, then `depth=1`.
  - At `PC=45`, CALL idx 1 → `depth=2`.
  - RET → `destination=46`, then RET → `destination=11`, `depth=0`.
- **Overflow/underflow:**
  - Five CALLs → the 5th has `jump_en=0`, `depth` stays 4, `stack_err=1`.
  - After `init`, a RET at `depth=0` → `jump_en=0`, `stack_err=1` persists across later valid ops.
  - CALL at `PC=1023` pushes 0.
- **Halt:** `halt=1` with CALL → `jump_en=0`, `depth` unchanged. A `flag_we` pulse during halt still updates Z, confirmed by a BEQ after `halt` drops.
